// File: rtl/sobel_edge_engine.sv
// Streaming Sobel edge engine: reads an IMG_W x IMG_H image from RAM, writes |Gx|+|Gy| (saturated) back.
// Optional macro THRESHOLD_EN adds a threshold input and turns the output into a binary edge map.
module sobel_edge_engine #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 12
) (
  input  logic              clk_50M,
  input  logic              reset,
  input  logic              clk_start,
  input  logic [ADDR_W-1:0] address_base,
  input  logic [ADDR_W-1:0] address_out,
`ifdef THRESHOLD_EN
  input  logic [PIX_W-1:0]  threshold,
`endif
  output logic [ADDR_W-1:0] address_pixel_in,
  input  logic [PIX_W-1:0]  pixel_in,
  output logic [ADDR_W-1:0] address_pixel_out,
  output logic [PIX_W-1:0]  pixel,
  output logic              wr_en,
  output logic              busy,
  output logic              clk_done
);

  localparam int N  = IMG_W * IMG_H;
  localparam int KW = $clog2(N + 1);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int DW = $clog2(IMG_W + 2);
  localparam int GW = PIX_W + 3;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addrRd_q, wrAddr_q, nextWr_q;
  logic [KW-1:0]     rdIdx_q, inCnt_q;
  logic              rdValid_q, dataValid_q;
  logic [CW-1:0]     colIn_q;
  logic [RW-1:0]     rowIn_q;
  logic [DW-1:0]     drainLeft_q;
  logic [PIX_W-1:0]  pix_q;
  logic              wrEn_q, busy_q, done_q;
  logic [PIX_W-1:0]  lb1_q [IMG_W];
  logic [PIX_W-1:0]  lb2_q [IMG_W];
  logic [PIX_W-1:0]  w0Top_q, w0Mid_q, w0Bot_q, w1Top_q, w1Mid_q, w1Bot_q;
  logic [PIX_W-1:0]  thr_q;

  logic [PIX_W-1:0]  colTop, colMid;
  logic signed [GW-1:0] gx, gy;
  logic [GW-1:0]     ax, ay;
  logic [PIX_W+3:0]  mag;
  logic [PIX_W-1:0]  satMag;
  logic              border;
  logic [PIX_W-1:0]  pixel_d;

  assign address_pixel_in  = addrRd_q;
  assign address_pixel_out = wrAddr_q;
  assign pixel             = pix_q;
  assign wr_en             = wrEn_q;
  assign busy              = busy_q;
  assign clk_done          = done_q;

  function automatic logic signed [GW-1:0] sx(input logic [PIX_W-1:0] p);
    return $signed({3'b000, p});
  endfunction

  // Right window column is formed on the fly from the line buffers and the incoming pixel.
  always_comb begin
    colTop = lb2_q[colIn_q];
    colMid = lb1_q[colIn_q];
    gx = (sx(colTop) + (sx(colMid) <<< 1) + sx(pixel_in))
       - (sx(w0Top_q) + (sx(w0Mid_q) <<< 1) + sx(w0Bot_q));
    gy = (sx(w0Bot_q) + (sx(w1Bot_q) <<< 1) + sx(pixel_in))
       - (sx(w0Top_q) + (sx(w1Top_q) <<< 1) + sx(colTop));
    ax = gx[GW-1] ? -gx : gx;
    ay = gy[GW-1] ? -gy : gy;
    mag = {1'b0, ax} + {1'b0, ay};
    satMag = (|mag[PIX_W+3:PIX_W]) ? {PIX_W{1'b1}} : mag[PIX_W-1:0];
    // Window columns wrapping across rows, and rows above the image, only ever feed border centres.
    border = (colIn_q < CW'(2)) || (rowIn_q < RW'(2));
`ifdef THRESHOLD_EN
    pixel_d = (mag >= {4'b0000, thr_q}) ? {PIX_W{1'b1}} : '0;
`else
    pixel_d = satMag;
`endif
    if (border) pixel_d = '0;
  end

`ifdef THRESHOLD_EN
  logic [PIX_W-1:0] thr_d;
  assign thr_d = threshold;
`else
  logic [PIX_W-1:0] thr_d;
  assign thr_d = '0;
`endif

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addrRd_q    <= '0;
      wrAddr_q    <= '0;
      nextWr_q    <= '0;
      rdIdx_q     <= '0;
      inCnt_q     <= '0;
      rdValid_q   <= 1'b0;
      dataValid_q <= 1'b0;
      colIn_q     <= '0;
      rowIn_q     <= '0;
      drainLeft_q <= '0;
      pix_q       <= '0;
      wrEn_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      thr_q       <= '0;
      w0Top_q <= '0; w0Mid_q <= '0; w0Bot_q <= '0;
      w1Top_q <= '0; w1Mid_q <= '0; w1Bot_q <= '0;
      for (int i = 0; i < IMG_W; i++) begin
        lb1_q[i] <= '0;
        lb2_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          wrEn_q <= 1'b0;
          done_q <= 1'b0;
          if (clk_start) begin
            state_q     <= READ;
            busy_q      <= 1'b1;
            addrRd_q    <= address_base;
            nextWr_q    <= address_out;
            thr_q       <= thr_d;
            rdIdx_q     <= '0;
            inCnt_q     <= '0;
            rdValid_q   <= 1'b1;
            dataValid_q <= 1'b0;
            colIn_q     <= '0;
            rowIn_q     <= '0;
          end
        end
        READ: begin
          wrEn_q      <= 1'b0;
          dataValid_q <= rdValid_q;
          if (rdValid_q) begin
            if (rdIdx_q == KW'(N - 1)) begin
              rdValid_q <= 1'b0;
            end else begin
              rdIdx_q  <= rdIdx_q + 1'b1;
              addrRd_q <= addrRd_q + 1'b1;
            end
          end
          if (dataValid_q) begin
            lb2_q[colIn_q] <= colMid;
            lb1_q[colIn_q] <= pixel_in;
            w0Top_q <= w1Top_q; w0Mid_q <= w1Mid_q; w0Bot_q <= w1Bot_q;
            w1Top_q <= colTop;  w1Mid_q <= colMid;  w1Bot_q <= pixel_in;
            if (colIn_q == CW'(IMG_W - 1)) begin
              colIn_q <= '0;
              rowIn_q <= rowIn_q + 1'b1;
            end else begin
              colIn_q <= colIn_q + 1'b1;
            end
            inCnt_q <= inCnt_q + 1'b1;
            if (inCnt_q >= KW'(IMG_W + 1)) begin
              wrEn_q   <= 1'b1;
              pix_q    <= pixel_d;
              wrAddr_q <= nextWr_q;
              nextWr_q <= nextWr_q + 1'b1;
            end
            if (inCnt_q == KW'(N - 1)) begin
              state_q     <= DRAIN;
              drainLeft_q <= DW'(IMG_W + 1);
            end
          end
        end
        DRAIN: begin
          wrEn_q      <= 1'b1;
          pix_q       <= '0;
          wrAddr_q    <= nextWr_q;
          nextWr_q    <= nextWr_q + 1'b1;
          drainLeft_q <= drainLeft_q - 1'b1;
          if (drainLeft_q == DW'(1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          wrEn_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sobel_edge_engine.md
Name: sobel_edge_engine

Overview:
Parametrised streaming Sobel edge-detection coprocessor. It reads a greyscale image of IMG_W x IMG_H pixels from a synchronous RAM, one pixel per cycle, starting at address_base. Two internal line buffers plus a 3x3 window compute the gradient magnitude, and the result image is written back at address_out. The block replaces the fixed 64-pixel row-register prototype and sits between the host control registers and the shared pixel RAM.

Parameters:
IMG_W, 64, image width in pixels (>=3)
IMG_H, 64, image height in pixels (>=3)
PIX_W, 8, bits per pixel
ADDR_W, 12, RAM address width; IMG_W*IMG_H must be <= 2^ADDR_W

Ports:
clk_50M  in  1  system clock
reset  in  1  asynchronous, active-high reset
clk_start  in  1  single-cycle start pulse
address_base  in  ADDR_W  source image base address
address_out  in  ADDR_W  destination image base address
address_pixel_in  out  ADDR_W  RAM read address
pixel_in  in  PIX_W  RAM read data; valid 1 cycle after address_pixel_in
address_pixel_out  out  ADDR_W  RAM write address
pixel  out  PIX_W  RAM write data
wr_en  out  1  write strobe
busy  out  1  high from the cycle after an accepted start until done
clk_done  out  1  one-cycle completion pulse

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; counters and line buffers cleared.
- FSM states: IDLE -> READ -> DRAIN -> DONE -> IDLE.
- IDLE: on clk_start, latch address_base/address_out, clear counters, go to READ. While busy, clk_start is ignored.
- READ: issue reads k = 0..N-1, with N = IMG_W*IMG_H, at address_base+k, one per cycle. Go to DRAIN after the last read data is consumed.
- Pixel k enters the window and line buffers the cycle its data is valid.
- Once k >= IMG_W+1, produce output index j = k-IMG_W-1, with center row r = j/IMG_W and col c = j%IMG_W. The write is registered: wr_en is high the cycle after pixel k is valid.
- Output value: if r==0, r==IMG_H-1, c==0 or c==IMG_W-1, write 0. Otherwise Gx = (p02+2p12+p22)-(p00+2p10+p20) and Gy = (p20+2p21+p22)-(p00+2p01+p02). Both are signed, PIX_W+3 bits.
- mag = |Gx|+|Gy|, saturated to 2^PIX_W-1.
- Window columns that wrap across rows only ever feed border centres, so they are always zeroed.
- DRAIN: write the remaining IMG_W+1 indices (N-IMG_W-1..N-1) as 0, one per cycle, consecutively.
- Write ordering: exactly N writes, address_out+0..N-1, strictly incrementing, no gaps in index. Addresses wrap modulo 2^ADDR_W.
- DONE: clk_done=1 for one cycle, busy=0 in the same cycle, then IDLE.
- Reset asserted mid-operation: immediate return to IDLE, wr_en=0, no further reads or writes. A new clk_start restarts from index 0.
- clk_start in the same cycle as DONE is ignored; it is accepted only in IDLE.

Optional Feature:
THRESHOLD_EN.
- Defined: adds input port threshold [PIX_W-1:0], sampled at start. Output = (mag >= threshold) ? 2^PIX_W-1 : 0, giving a binary edge map. Border pixels stay 0.
- Undefined: no threshold port; output is the saturated magnitude.

Test Plan:
- IMG_W=IMG_H=4, constant image 50 -> 16 writes at address_out+0..15, all 0, one clk_done pulse.
- 4x4, columns 0-1 = 0 and columns 2-3 = 10 (vertical step) -> interior centres (1,1),(1,2),(2,1),(2,2) = 40; borders 0.
- 4x4, rows 0-1 = 0 and rows 2-3 = 10 (horizontal step) -> interior = 40 via Gy; borders 0.
- 4x4, vertical step 0/255 -> interior saturates to 255.
- THRESHOLD_EN with threshold=30 on the vertical-step image -> interior 255; with threshold=41 -> interior 0.
- Reset pulsed at write 5, then restart -> no writes after reset; restarted run produces all 16 correct writes. A second clk_start mid-run is ignored.
